// File: rtl/fp_mul_result_buffer.sv
// rtl/fp_mul_result_buffer.sv - result FIFO for floating-point multiplier products with exception tracking
//
// Buffers multiplier products together with their exception flags in a small
// FIFO, and keeps sticky flags plus saturating per-flag counters over all
// accepted entries.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid / in_ready        producer handshake
//   in_data                    product word
//   in_underflow/overflow/invalid  product exception flags
//   out_valid / out_ready      consumer handshake
//   out_data, out_flags        head entry ({invalid, overflow, underflow})
//   level                      current occupancy
//   sticky_flags               accumulated {invalid, overflow, underflow}
//   clear_sticky               clears sticky flags and counters
//   underflow/overflow/invalid_count  saturating counts of flagged entries
module fp_mul_result_buffer #(
    parameter int ExponentWidth = 8,
    parameter int MantissaWidth = 23,
    parameter int Depth         = 4,
    parameter int CountWidth    = 8,
    localparam int FloatBitWidth = ExponentWidth + MantissaWidth + 1,
    localparam int LevelWidth    = $clog2(Depth) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FloatBitWidth-1:0] in_data,
    input  logic                     in_underflow,
    input  logic                     in_overflow,
    input  logic                     in_invalid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FloatBitWidth-1:0] out_data,
    output logic [2:0]               out_flags,
    output logic [LevelWidth-1:0]    level,
    output logic [2:0]               sticky_flags,
    input  logic                     clear_sticky,
    output logic [CountWidth-1:0]    underflow_count,
    output logic [CountWidth-1:0]    overflow_count,
    output logic [CountWidth-1:0]    invalid_count
);

    localparam int PtrWidth = $clog2(Depth);
    localparam logic [CountWidth-1:0] CountMax = {CountWidth{1'b1}};

    logic [FloatBitWidth-1:0] data_mem [Depth];
    logic [2:0]               flag_mem [Depth];
    logic [PtrWidth-1:0]      rd_ptr;
    logic [PtrWidth-1:0]      wr_ptr;

    logic       push;
    logic       pop;
    logic [2:0] in_flags;
    logic [2:0] push_flags;

    // Handshakes depend only on registered occupancy, so no input reaches
    // an output combinationally.
    assign in_ready   = (level < LevelWidth'(Depth));
    assign out_valid  = (level != '0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign in_flags   = {in_invalid, in_overflow, in_underflow};
    assign push_flags = push ? in_flags : 3'b000;

    // Storage is cleared on reset so the head reads as zero until the first push.
    assign out_data  = data_mem[rd_ptr];
    assign out_flags = flag_mem[rd_ptr];

    // Clear takes effect first; a flagged push in the same cycle then counts once.
    function automatic logic [CountWidth-1:0] count_next(
        input logic [CountWidth-1:0] cur,
        input logic                  clr,
        input logic                  hit
    );
        logic [CountWidth-1:0] base;
        base = clr ? '0 : cur;
        if (hit && (base != CountMax)) begin
            return base + CountWidth'(1);
        end
        return base;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                data_mem[i] <= '0;
                flag_mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= in_data;
                flag_mem[wr_ptr] <= in_flags;
                wr_ptr           <= wr_ptr + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrWidth'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LevelWidth'(1);
                2'b01:   level <= level - LevelWidth'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_flags    <= '0;
            underflow_count <= '0;
            overflow_count  <= '0;
            invalid_count   <= '0;
        end else begin
            sticky_flags    <= (clear_sticky ? 3'b000 : sticky_flags) | push_flags;
            underflow_count <= count_next(underflow_count, clear_sticky, push_flags[0]);
            overflow_count  <= count_next(overflow_count,  clear_sticky, push_flags[1]);
            invalid_count   <= count_next(invalid_count,   clear_sticky, push_flags[2]);
        end
    end

endmodule

// File: doc/fp_mul_result_buffer.md
FP_MUL_RESULT_BUFFER -- requirements
Module: fp_mul_result_buffer

Interface
REQ-001 SHALL have parameter ExponentWidth, default 8, exponent field width of the carried float.
REQ-002 SHALL have parameter MantissaWidth, default 23, mantissa field width; FloatBitWidth = ExponentWidth + MantissaWidth + 1.
REQ-003 SHALL have parameter Depth, default 4, entry count; power of two, at least 2.
REQ-004 SHALL have parameter CountWidth, default 8, width of each exception counter.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, multiplier product and flags present.
REQ-008 SHALL have port in_ready, output, 1, buffer can accept an entry this cycle.
REQ-009 SHALL have port in_data, input, FloatBitWidth, product from floating_point_multiplier out.
REQ-010 SHALL have ports in_underflow, in_overflow, in_invalid, input, 1 each, multiplier exception flags.
REQ-011 SHALL have port out_valid, output, 1, head entry present.
REQ-012 SHALL have port out_ready, input, 1, consumer takes head entry.
REQ-013 SHALL have port out_data, output, FloatBitWidth, head entry product.
REQ-014 SHALL have port out_flags, output, 3, head entry flags {invalid, overflow, underflow}.
REQ-015 SHALL have port level, output, $clog2(Depth)+1, current occupancy.
REQ-016 SHALL have port sticky_flags, output, 3, accumulated {invalid, overflow, underflow} since last clear.
REQ-017 SHALL have port clear_sticky, input, 1, single-cycle clear of sticky flags and counters.
REQ-018 SHALL have ports underflow_count, overflow_count, invalid_count, output, CountWidth each, accepted-entry flag counts.

Function
REQ-019 SHALL accept (push) when in_valid and in_ready are both 1 on a rising edge; SHALL pop when out_valid and out_ready are both 1.
REQ-020 SHALL drive in_ready = (level < Depth), registered-state only, no dependence on out_ready.
REQ-021 SHALL drive out_valid = (level != 0); out_data/out_flags SHALL reflect the oldest entry, stable while out_valid=1 and out_ready=0.
REQ-022 SHALL have latency of exactly 1 cycle: an entry pushed at edge N is visible at the output after edge N; no combinational input-to-output path.
REQ-023 SHALL, on simultaneous push and pop with 0 < level < Depth, keep level unchanged and preserve order.
REQ-024 SHALL, when full, reject input (in_ready=0) even if a pop occurs the same cycle; level decrements by 1.
REQ-025 SHALL ignore out_ready when empty and in_valid when full; no state change from ignored requests.
REQ-026 SHALL use wrap-around read/write pointers modulo Depth; FIFO order maintained across wrap.
REQ-027 SHALL store data and flags bit-exact; no NaN canonicalisation or rounding.
REQ-028 SHALL, on each accepted push, OR the three input flags into sticky_flags.
REQ-029 SHALL, on each accepted push, increment each counter whose flag is 1, saturating at 2^CountWidth-1.
REQ-030 SHALL, when clear_sticky=1, zero sticky_flags and all counters; if a flagged push is accepted in the same cycle, the result SHALL be the cleared value plus that push (flag set, count 1).
REQ-031 SHALL not let clear_sticky affect FIFO contents or level.

Reset
REQ-032 SHALL, when rst=1 at a rising edge, set level=0, out_valid=0, in_ready=1, pointers=0, sticky_flags=0, all counters=0.
REQ-033 SHALL give rst priority over push, pop and clear_sticky in the same cycle; contents discarded mid-operation.
REQ-034 SHALL drive out_data/out_flags to 0 after reset until the first push.

Verification
REQ-035 SHALL cover: push 0x41400000 flags 000, out_ready=0 -> next cycle out_valid=1, out_data=0x41400000, level=1, stable until out_ready=1.
REQ-036 SHALL cover: push 5 entries back-to-back with Depth=4, out_ready=0 -> in_ready=0 after 4th, 5th not accepted, level=4; drain returns 4 in order.
REQ-037 SHALL cover: full buffer, in_valid=1 and out_ready=1 together -> pop only, level 4->3, in_ready=1 next cycle.
REQ-038 SHALL cover: push 0x7F800000 flags 010, then 0xFFC00000 flags 100 -> sticky_flags=110, overflow_count=1, invalid_count=1.
REQ-039 SHALL cover: clear_sticky=1 with accepted push of 0x00000000 flags 001 -> sticky_flags=001, underflow_count=1, others 0.
REQ-040 SHALL cover: 300 pushes of flags 001 with CountWidth=8 -> underflow_count saturates at 255; rst asserted with level=3 -> level=0, out_valid=0 next cycle.
